life_engine: RTL
================

Name: life_engine

Overview:
Parametrised, row-parallel Game of Life engine. It is the successor to the bit-serial life top level.
- Holds an X*Y grid and computes one full generation in Y cycles, one row of X cells per cycle, updating the grid in place.
- Adds programmable birth/survive rules, selectable torus or dead-border edges, a run-rate divider, a generation counter, and extinct/stable status flags.
- Sits between the debounced key inputs and the display scanner, which reads the grid bus.

Parameters:
X, 8, grid width in cells (>=3)
Y, 8, grid height in cells (>=3)
LOG2X, 3, cursor_x width, ceil(log2 X)
LOG2Y, 3, cursor_y width, ceil(log2 Y)
GEN_W, 16, generation counter width
RUN_DIV, 4, idle cycles between generations in run mode (>=1)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
key_step  in  1  single-cycle pulse: compute one generation
key_run  in  1  level: free-running generations
key_flip  in  1  pulse: toggle the cell under the cursor
key_up  in  1  pulse: cursor_y-1
key_down  in  1  pulse: cursor_y+1
key_left  in  1  pulse: cursor_x-1
key_right  in  1  pulse: cursor_x+1
wrap  in  1  1=torus edges, 0=dead border
birth_mask  in  9  bit n set: a dead cell with n neighbours is born
survive_mask  in  9  bit n set: a live cell with n neighbours survives
grid  out  X*Y  cell (x,y) at bit y*X+x; row 0 = bits X-1:0
cursor_x  out  LOG2X  cursor column
cursor_y  out  LOG2Y  cursor row
busy  out  1  high while computing
gen_cnt  out  GEN_W  completed generations
extinct  out  1  last generation produced an all-zero grid
stable  out  1  last generation equal to its predecessor

Behaviour:
- Reset (async, any state, including mid-generation):
  - grid=0, cursor=(0,0), gen_cnt=0, busy=0, extinct=0, stable=0.
  - State IDLE, divider=0, internal row counter and row buffers cleared.
- States:
  - IDLE: edits and start allowed.
  - COMPUTE: exactly Y cycles.
  - Then back to IDLE.
- Edits (IDLE only; ignored while busy):
  - Flip applies to the current cursor before movement in the same cycle.
  - up+down in the same cycle cancel; left+right in the same cycle cancel.
  - Cursor wraps modulo X/Y: left at x=0 gives X-1, down at y=Y-1 gives 0.
- Start:
  - key_step in IDLE enters COMPUTE on the next edge. key_step while busy is dropped (not queued).
  - key_run=1 in IDLE: divider increments each cycle; when divider==RUN_DIV-1, enter COMPUTE and clear divider.
  - key_run=0: divider held at 0.
  - Run-mode period = Y+RUN_DIV cycles.
  - step and run together: step wins immediately, divider cleared.
  - Edits in the start cycle are applied first.
- Latching: wrap, birth_mask and survive_mask are latched on COMPUTE entry and held for the whole generation.
- COMPUTE, cycle k (k=0..Y-1), processes row k:
  - Neighbour sources: original row k-1 from the prev_row buffer (saved before row k-1 was overwritten), row k and row k+1 from grid (still original).
  - Torus mode: row Y-1 uses the saved copy of original row 0 as its lower neighbour. Row 0 uses row Y-1 (unmodified at k=0) as its upper neighbour. Columns wrap modulo X.
  - Dead-border mode: out-of-grid neighbours are 0.
  - n = count of 8 neighbours, 0..8 (4-bit). new = alive ? survive_mask[n] : birth_mask[n].
  - Row k of grid is written on the edge ending cycle k.
  - A change flag ORs (new_row != old_row); an any-alive flag ORs new_row.
- Completion, on the edge ending cycle Y-1:
  - gen_cnt+1, wrapping at 2^GEN_W to 0.
  - extinct = !any_alive; stable = !change.
  - Flags hold until the next completion; state returns to IDLE and busy falls.
- busy=1 exactly during the Y COMPUTE cycles. grid is valid for display only when busy=0.

Test Plan:
- Blinker at (1..3,2), 8x8, wrap=1, birth_mask=0x008, survive_mask=0x00C, key_step -> busy high exactly 8 cycles; grid = cells (2,1),(2,2),(2,3); gen_cnt=1; stable=0; extinct=0.
- 2x2 block at (3..4,3..4), key_step -> grid unchanged, stable=1, extinct=0.
- Vertical blinker at x=0, y=3..5: wrap=1 -> cells (7,4),(0,4),(1,4). Same start with wrap=0 -> (0,4),(1,4); second step -> grid=0, extinct=1.
- Glider (1,0),(2,1),(0,2),(1,2),(2,2), wrap=1, key_run=1, RUN_DIV=4 -> a new generation starts every 12 cycles; at gen_cnt=32 the grid equals the initial pattern.
- Cursor: from reset, key_left, key_up, key_flip -> cursor=(7,7), grid bit 63=1. key_flip asserted while busy -> no change.
- Async reset asserted at COMPUTE cycle 4 -> all outputs at reset values immediately. After release, key_step on an empty grid -> extinct=1, gen_cnt=1.

Source files
------------

// File: rtl/life_engine.sv
// life_engine: row-parallel Game of Life engine with programmable rules,
// torus/dead-border edges, run-rate divider, generation counter and status flags.
// Ports: clk, reset (async, active-high); key_* debounced key pulses (key_run is a level);
// wrap selects torus edges; birth_mask/survive_mask index by neighbour count;
// grid holds cell (x,y) at bit y*X+x; cursor_x/cursor_y edit cursor; busy while computing;
// gen_cnt completed generations; extinct/stable describe the last completed generation.
module life_engine #(
    parameter int X       = 8,
    parameter int Y       = 8,
    parameter int LOG2X   = 3,
    parameter int LOG2Y   = 3,
    parameter int GEN_W   = 16,
    parameter int RUN_DIV = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_step,
    input  logic               key_run,
    input  logic               key_flip,
    input  logic               key_up,
    input  logic               key_down,
    input  logic               key_left,
    input  logic               key_right,
    input  logic               wrap,
    input  logic [8:0]         birth_mask,
    input  logic [8:0]         survive_mask,
    output logic [X*Y-1:0]     grid,
    output logic [LOG2X-1:0]   cursor_x,
    output logic [LOG2Y-1:0]   cursor_y,
    output logic               busy,
    output logic [GEN_W-1:0]   gen_cnt,
    output logic               extinct,
    output logic               stable
);
    localparam int DW = RUN_DIV > 1 ? $clog2(RUN_DIV) : 1;
    localparam int GW = $clog2(X*Y);

    typedef enum logic {IDLE, COMPUTE} state_t;

    state_t             state_q, state_d;
    logic [X*Y-1:0]     grid_q, grid_d;
    logic [LOG2X-1:0]   cx_q, cx_d;
    logic [LOG2Y-1:0]   cy_q, cy_d;
    logic [LOG2Y-1:0]   row_q, row_d;
    logic [DW-1:0]      div_q, div_d;
    logic [GEN_W-1:0]   gen_q, gen_d;
    logic [X-1:0]       prev_q, prev_d;
    logic [X-1:0]       row0_q, row0_d;
    logic               wrap_q, wrap_d;
    logic [8:0]         birth_q, birth_d;
    logic [8:0]         surv_q, surv_d;
    logic               change_q, change_d;
    logic               alive_q, alive_d;
    logic               extinct_q, extinct_d;
    logic               stable_q, stable_d;

    logic [GW-1:0]      rb, nb, cidx;
    logic [X-1:0]       cur_row, up_row, dn_row, new_row;
    logic [X+1:0]       up_p, cur_p, dn_p;
    logic [3:0]         n;
    logic               start;

    // Neighbourhood of the row being processed. The row above comes from the
    // saved original (the grid copy is already overwritten); the row below is
    // still original in the grid except for the last row, whose torus
    // neighbour is the saved copy of original row 0.
    always_comb begin
        rb      = GW'(row_q * X);
        nb      = GW'((row_q + 1) * X);
        cur_row = grid_q[rb +: X];
        up_row  = (row_q == '0) ? (wrap_q ? grid_q[(Y-1)*X +: X] : '0) : prev_q;
        dn_row  = (row_q == LOG2Y'(Y-1)) ? (wrap_q ? row0_q : '0) : grid_q[nb +: X];
        // Pad each row by one column on each side: wrapped cells or zeros.
        up_p    = {wrap_q & up_row[0], up_row, wrap_q & up_row[X-1]};
        cur_p   = {wrap_q & cur_row[0], cur_row, wrap_q & cur_row[X-1]};
        dn_p    = {wrap_q & dn_row[0], dn_row, wrap_q & dn_row[X-1]};
        n       = '0;
        new_row = '0;
        for (int i = 0; i < X; i++) begin
            n = 4'(up_p[i]) + 4'(up_p[i+1]) + 4'(up_p[i+2]) + 4'(cur_p[i]) + 4'(cur_p[i+2])
              + 4'(dn_p[i]) + 4'(dn_p[i+1]) + 4'(dn_p[i+2]);
            new_row[i] = cur_row[i] ? surv_q[n] : birth_q[n];
        end
    end

    always_comb begin
        state_d   = state_q;
        grid_d    = grid_q;
        cx_d      = cx_q;
        cy_d      = cy_q;
        row_d     = row_q;
        div_d     = div_q;
        gen_d     = gen_q;
        prev_d    = prev_q;
        row0_d    = row0_q;
        wrap_d    = wrap_q;
        birth_d   = birth_q;
        surv_d    = surv_q;
        change_d  = change_q;
        alive_d   = alive_q;
        extinct_d = extinct_q;
        stable_d  = stable_q;
        start     = 1'b0;
        cidx      = GW'(cy_q * X + cx_q);
        if (state_q == IDLE) begin
            // Flip uses the cursor before this cycle's movement.
            if (key_flip) grid_d[cidx] = ~grid_q[cidx];
            cx_d = (key_left == key_right) ? cx_q
                 : key_right ? ((cx_q == LOG2X'(X-1)) ? '0 : cx_q + 1'b1)
                 : ((cx_q == '0) ? LOG2X'(X-1) : cx_q - 1'b1);
            cy_d = (key_up == key_down) ? cy_q
                 : key_down ? ((cy_q == LOG2Y'(Y-1)) ? '0 : cy_q + 1'b1)
                 : ((cy_q == '0) ? LOG2Y'(Y-1) : cy_q - 1'b1);
            start = key_step | (key_run & (div_q == DW'(RUN_DIV-1)));
            div_d = (key_run & !start) ? div_q + 1'b1 : '0;
            if (start) begin
                state_d  = COMPUTE;
                row_d    = '0;
                wrap_d   = wrap;
                birth_d  = birth_mask;
                surv_d   = survive_mask;
                change_d = 1'b0;
                alive_d  = 1'b0;
            end
        end else begin
            grid_d[rb +: X] = new_row;
            prev_d   = cur_row;
            row0_d   = (row_q == '0) ? cur_row : row0_q;
            change_d = change_q | (new_row != cur_row);
            alive_d  = alive_q | (|new_row);
            row_d    = row_q + 1'b1;
            if (row_q == LOG2Y'(Y-1)) begin
                state_d   = IDLE;
                row_d     = '0;
                gen_d     = gen_q + 1'b1;
                extinct_d = !alive_d;
                stable_d  = !change_d;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grid_q    <= '0;
            cx_q      <= '0;
            cy_q      <= '0;
            row_q     <= '0;
            div_q     <= '0;
            gen_q     <= '0;
            prev_q    <= '0;
            row0_q    <= '0;
            wrap_q    <= 1'b0;
            birth_q   <= '0;
            surv_q    <= '0;
            change_q  <= 1'b0;
            alive_q   <= 1'b0;
            extinct_q <= 1'b0;
            stable_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            grid_q    <= grid_d;
            cx_q      <= cx_d;
            cy_q      <= cy_d;
            row_q     <= row_d;
            div_q     <= div_d;
            gen_q     <= gen_d;
            prev_q    <= prev_d;
            row0_q    <= row0_d;
            wrap_q    <= wrap_d;
            birth_q   <= birth_d;
            surv_q    <= surv_d;
            change_q  <= change_d;
            alive_q   <= alive_d;
            extinct_q <= extinct_d;
            stable_q  <= stable_d;
        end
    end

    assign grid     = grid_q;
    assign cursor_x = cx_q;
    assign cursor_y = cy_q;
    assign busy     = (state_q == COMPUTE);
    assign gen_cnt  = gen_q;
    assign extinct  = extinct_q;
    assign stable   = stable_q;
endmodule
